display_serializer: RTL and testbench

- Parametrised successor to the single-width seven-segment shift-register output path.
- Serialises a frame of NUM_DIGITS x SEG_BITS segment bits to a daisy-chained external shift-register/latch.
- Adds a configurable serial clock rate, bit order and latch width, per-digit blanking, and common-anode inversion.
- Accepts one queued update while a frame is in flight and flags overruns; sits between the segment encoder and the chip pins.

---
 rtl/display_serializer.sv | 173 +++++++++++++++++
 tb/tb_display_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_serializer.sv
// Serialises a NUM_DIGITS x SEG_BITS segment frame to a daisy-chained shift-register/latch,
// with one queued frame slot, per-digit blanking and optional inversion.
module display_serializer #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned SEG_BITS     = 7,
    parameter int unsigned SCLK_DIV     = 2,
    parameter int unsigned MSB_FIRST    = 1,
    parameter int unsigned LATCH_CYCLES = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NUM_DIGITS*SEG_BITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]          blank_i,
    input  logic                           invert_i,
    output logic                           sclk_o,
    output logic                           data_o,
    output logic                           latch_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overrun_o
);

    localparam int unsigned W       = NUM_DIGITS * SEG_BITS;
    localparam int unsigned CNT_W   = $clog2(W + 1);
    localparam int unsigned DIV_MAX = (SCLK_DIV > LATCH_CYCLES) ? SCLK_DIV : LATCH_CYCLES;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(LATCH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     sr_q,    sr_d;
    logic             pend_q,  pend_d;
    logic [W-1:0]     pbuf_q,  pbuf_d;
    logic             sclk_q,  sclk_d;
    logic             data_q,  data_d;
    logic             latch_q, latch_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [W-1:0]     blank_mask;
    logic [W-1:0]     formed;
    logic [W-1:0]     sr_shift;

    // Expand the per-digit blank mask to segment bits.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_blank
        assign blank_mask[d*SEG_BITS +: SEG_BITS] = {SEG_BITS{blank_i[d]}};
    end

    assign formed   = (data_i & ~blank_mask) ^ {W{invert_i}};
    assign sr_shift = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        pend_d  = pend_q;
        pbuf_d  = pbuf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending frame takes priority; a coincident start refills the slot.
                if (pend_q) begin
                    sr_d    = pbuf_q;
                    cnt_d   = CNT_W'(W);
                    div_d   = '0;
                    state_d = ST_LOW;
                    pend_d  = start_i;
                    if (start_i) begin
                        pbuf_d = formed;
                    end
                end else if (start_i) begin
                    sr_d    = formed;
                    cnt_d   = CNT_W'(W);
                    div_d   = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sr_d    = sr_shift;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? ST_LATCH : ST_LOW;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_q == LAT_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && start_i) begin
            pend_d = 1'b1;
            pbuf_d = formed;
        end

        // Outputs are registered from the next state so they line up with it.
        sclk_d  = (state_d == ST_HIGH);
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
        if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
            data_d = (MSB_FIRST != 0) ? sr_d[W-1] : sr_d[0];
        end else begin
            data_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            pend_q  <= 1'b0;
            pbuf_q  <= '0;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            pend_q  <= pend_d;
            pbuf_q  <= pbuf_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign data_o    = data_q;
    assign latch_o   = latch_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    // Overrun must flag in the same cycle the queued frame is overwritten.
    assign overrun_o = start_i & busy_q & pend_q;

endmodule

// File: tb/tb_display_serializer.sv
// Bench for display_serializer: three parameterisations checked every cycle against a
// frame-timeline model, plus literal timing points.
module tb_display_serializer;

    typedef struct {
        bit          active;
        int          t0;
        logic [63:0] word;
        bit          pend;
        logic [63:0] pword;
    } mstate_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 0, inv0 = 0;
    logic [41:0] data0 = '0;
    logic [5:0]  blank0 = '0;
    logic        sclk0, sdata0, latch0, busy0, done0, ovr0;

    logic        start1 = 0, inv1 = 0;
    logic [6:0]  data1 = '0;
    logic [0:0]  blank1 = '0;
    logic        sclk1, sdata1, latch1, busy1, done1, ovr1;

    logic        start2 = 0, inv2 = 0;
    logic [7:0]  data2 = '0;
    logic [1:0]  blank2 = '0;
    logic        sclk2, sdata2, latch2, busy2, done2, ovr2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sA = -100000;
    int sD = -100000;
    int sE = -100000;

    mstate_t m0 = '{default: 0};
    mstate_t m1 = '{default: 0};
    mstate_t m2 = '{default: 0};

    display_serializer u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .data_i(data0), .blank_i(blank0),
        .invert_i(inv0), .sclk_o(sclk0), .data_o(sdata0), .latch_o(latch0),
        .busy_o(busy0), .done_o(done0), .overrun_o(ovr0)
    );

    display_serializer #(.NUM_DIGITS(1), .SEG_BITS(7), .SCLK_DIV(1), .MSB_FIRST(0),
                         .LATCH_CYCLES(1)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(data1), .blank_i(blank1),
        .invert_i(inv1), .sclk_o(sclk1), .data_o(sdata1), .latch_o(latch1),
        .busy_o(busy1), .done_o(done1), .overrun_o(ovr1)
    );

    display_serializer #(.NUM_DIGITS(2), .SEG_BITS(4), .SCLK_DIV(3), .MSB_FIRST(1),
                         .LATCH_CYCLES(4)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(data2), .blank_i(blank2),
        .invert_i(inv2), .sclk_o(sclk2), .data_o(sdata2), .latch_o(latch2),
        .busy_o(busy2), .done_o(done2), .overrun_o(ovr2)
    );

    function automatic logic [63:0] form(logic [63:0] d, logic [7:0] blank, bit inv,
                                         int sb, int w);
        logic [63:0] r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = (blank[i / sb] ? 1'b0 : d[i]) ^ inv;
        end
        return r;
    endfunction

    function automatic bit is_busy(mstate_t m, int c, int dv, int w, int l);
        int k = c - m.t0;
        return m.active && (k >= 1) && (k <= 2 * dv * w + l);
    endfunction

    // Expected {sclk, data, latch, busy, done, overrun} for cycle c.
    function automatic logic [5:0] mexp(mstate_t m, int c, int dv, int w, int l, bit msb,
                                        bit start);
        int k = c - m.t0;
        int span = 2 * dv * w;
        int j;
        logic [5:0] r = '0;
        if (m.active && k >= 1 && k <= span) begin
            j    = (k - 1) / (2 * dv);
            r[5] = ((k - 1) % (2 * dv)) >= dv;
            r[4] = msb ? m.word[w - 1 - j] : m.word[j];
            r[2] = 1'b1;
        end else if (m.active && k > span && k <= span + l) begin
            r[3] = 1'b1;
            r[2] = 1'b1;
        end else if (m.active && k == span + l + 1) begin
            r[1] = 1'b1;
        end
        r[0] = r[2] && start && m.pend;
        return r;
    endfunction

    function automatic mstate_t mnext(mstate_t m, int c, int dv, int w, int l, bit start,
                                      logic [63:0] f);
        mstate_t n = m;
        if (is_busy(m, c, dv, w, l)) begin
            if (start) begin
                n.pend  = 1'b1;
                n.pword = f;
            end
        end else begin
            n.active = 1'b0;
            if (m.pend) begin
                n.active = 1'b1;
                n.t0     = c;
                n.word   = m.pword;
                n.pend   = start;
                if (start) n.pword = f;
            end else if (start) begin
                n.active = 1'b1;
                n.t0     = c;
                n.word   = f;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
        end
    endtask

    // Compare process: every DUT output against the model, plus literal pins.
    always @(negedge clk) begin
        logic [5:0] e0, e1, e2;
        if (rst) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
            m2 = '{default: 0};
            e0 = '0; e1 = '0; e2 = '0;
        end else begin
            e0 = mexp(m0, cyc, 2, 42, 1, 1'b1, start0);
            e1 = mexp(m1, cyc, 1, 7, 1, 1'b0, start1);
            e2 = mexp(m2, cyc, 3, 8, 4, 1'b1, start2);
        end
        chk("u0_outputs", {2'b0, sclk0, sdata0, latch0, busy0, done0, ovr0}, {2'b0, e0});
        chk("u1_outputs", {2'b0, sclk1, sdata1, latch1, busy1, done1, ovr1}, {2'b0, e1});
        chk("u2_outputs", {2'b0, sclk2, sdata2, latch2, busy2, done2, ovr2}, {2'b0, e2});

        if (cyc == sA + 3)   begin chk("A_first_rise", 8'(sclk0), 1); chk("A_bit0", 8'(sdata0), 1); end
        if (cyc == sA + 7)   chk("A_bit1", 8'(sdata0), 0);
        if (cyc == sA + 167) chk("A_last_rise", 8'(sclk0), 1);
        if (cyc == sA + 169) chk("A_latch", 8'(latch0), 1);
        if (cyc == sA + 170) begin chk("A_done", 8'(done0), 1); chk("A_busy_gap", 8'(busy0), 0); end
        if (cyc == sA + 171) chk("C_busy", 8'(busy0), 1);
        if (cyc == sA + 50)  chk("B_no_overrun", 8'(ovr0), 0);
        if (cyc == sA + 60)  chk("C_overrun", 8'(ovr0), 1);
        if (cyc == sA + 173) chk("C_first_bit", 8'(sdata0), 1);
        if (cyc == sA + 337) chk("C_last_bit", 8'(sdata0), 1);
        if (cyc == sD + 3)   chk("D_first_bit", 8'(sdata0), 1);
        if (cyc == sD + 139) chk("D_digit1_bit0", 8'(sdata0), 1);
        if (cyc == sD + 143) chk("D_blank_bit6", 8'(sdata0), 0);
        if (cyc == sD + 167) chk("D_blank_bit0", 8'(sdata0), 0);
        if (cyc == sA + 1)   chk("u1_first_bit", 8'(sdata1), 1);
        if (cyc == sA + 3)   chk("u1_second_bit", 8'(sdata1), 0);
        if (cyc == sA + 14)  chk("u1_no_latch", 8'(latch1), 0);
        if (cyc == sA + 15)  chk("u1_latch", 8'(latch1), 1);
        if (cyc == sA + 16)  chk("u1_done", 8'(done1), 1);
        if (cyc == sA + 3)   chk("u2_low_end", 8'(sclk2), 0);
        if (cyc == sA + 4)   chk("u2_high_start", 8'(sclk2), 1);
        if (cyc == sA + 6)   chk("u2_high_end", 8'(sclk2), 1);
        if (cyc == sA + 7)   chk("u2_low_again", 8'(sclk2), 0);
        if (cyc == sA + 48)  chk("u2_pre_latch", 8'(latch2), 0);
        if (cyc == sA + 49)  chk("u2_latch_first", 8'(latch2), 1);
        if (cyc == sA + 52)  chk("u2_latch_last", 8'(latch2), 1);
        if (cyc == sA + 53)  begin chk("u2_done", 8'(done2), 1); chk("u2_latch_off", 8'(latch2), 0); end
        if (cyc == sE + 79)  chk("E_busy_before_rst", 8'(busy0), 1);
        if (cyc == sE + 80)  chk("E_rst_async", {3'b0, sclk0, sdata0, latch0, busy0, done0}, 0);

        if (!rst) begin
            m0 = mnext(m0, cyc, 2, 42, 1, start0, form(64'(data0), 8'(blank0), inv0, 7, 42));
            m1 = mnext(m1, cyc, 1, 7, 1, start1, form(64'(data1), 8'(blank1), inv1, 7, 7));
            m2 = mnext(m2, cyc, 3, 8, 4, start2, form(64'(data2), 8'(blank2), inv2, 4, 8));
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // Frame A on all instances; B and C queued on u0 (C overwrites B).
        sA = cyc;
        start0 = 1; data0 = 42'h2AA_AAAA_AAAA;
        start1 = 1; data1 = 7'b0000001;
        start2 = 1; data2 = 8'hA5;
        tick(1);
        start0 = 0; start1 = 0; start2 = 0;
        tick(49);
        start0 = 1; data0 = 42'h3FF_0000_1234;
        tick(1);
        start0 = 0;
        tick(9);
        start0 = 1; data0 = '0; blank0 = 6'b000001; inv0 = 1;
        tick(1);
        start0 = 0; blank0 = 6'b111111; inv0 = 0; data0 = 42'h155_5555_5555;
        tick(285);

        // Blanked digit without inversion.
        sD = cyc;
        start0 = 1; data0 = '1; blank0 = 6'b000001; inv0 = 0;
        tick(1);
        start0 = 0; blank0 = '0;
        tick(180);

        // Reset mid-frame with a pending frame.
        sE = cyc;
        start0 = 1; data0 = 42'h0F0_F0F0_F0F0;
        tick(1);
        start0 = 0;
        tick(49);
        start0 = 1; data0 = 42'h123_4567_89AB;
        tick(1);
        start0 = 0;
        tick(29);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(400);

        // Random traffic, inputs changing every cycle.
        for (int i = 0; i < 4000; i++) begin
            data0  = 42'({$urandom, $urandom});
            blank0 = 6'($urandom);
            inv0   = 1'($urandom);
            start0 = ($urandom_range(0, 39) == 0);
            data1  = 7'($urandom);
            blank1 = 1'($urandom);
            inv1   = 1'($urandom);
            start1 = ($urandom_range(0, 9) == 0);
            data2  = 8'($urandom);
            blank2 = 2'($urandom);
            inv2   = 1'($urandom);
            start2 = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        start0 = 0; start1 = 0; start2 = 0;
        tick(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
